// File: rtl/data_serializer.sv
// Parallel-to-serial converter: one WORDS*BITS word in,
// WORDS slices out, highest slice first, valid/ready on both sides.
module data_serializer #(
  parameter int BITS  = 8,
  parameter int WORDS = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [WORDS*BITS-1:0] i_Din,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [BITS-1:0]       o_Dout,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last
);

  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] TOP = CW'(WORDS - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e                     state_q, state_d;
  logic [WORDS-1:0][BITS-1:0] word_q, word_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [CW-1:0]              cnt_m1;
  logic [BITS-1:0]            dout_q, dout_d;
  logic                       last_q, last_d;
  logic                       in_xfer;
  logic                       out_xfer;

  assign o_valid = (state_q == SEND);
  assign o_Dout  = dout_q;
  assign o_last  = last_q;

  // Accept a new word when idle, or alongside the last-slice handshake
  always_comb begin
    o_ready = 1'b0;
    if (i_rst) begin
      if (state_q == IDLE) o_ready = 1'b1;
      else                 o_ready = last_q & i_ready;
    end
  end

  assign in_xfer  = i_valid & o_ready;
  assign out_xfer = o_valid & i_ready;
  assign cnt_m1   = cnt_q - CW'(1);

  // Next state: load a word, step down through slices, or go idle
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    last_d  = last_q;
    if (in_xfer) begin
      state_d = SEND;
      word_d  = i_Din;
      cnt_d   = TOP;
      dout_d  = i_Din[WORDS*BITS-1 -: BITS];
      last_d  = (WORDS == 1);
    end else if (out_xfer) begin
      if (cnt_q != '0) begin
        cnt_d  = cnt_m1;
        dout_d = word_q[cnt_m1];
        last_d = (cnt_m1 == '0);
      end else begin
        state_d = IDLE;
        last_d  = 1'b0;
      end
    end
  end

  // State registers; reset discards any partial word
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_data_serializer.sv
// Scoreboard bench for data_serializer (WORDS=4 and WORDS=1).
// Accepted words are expanded into expected slices, monitors pop.
module tb_data_serializer;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] din4;
  logic        v4, rdy4, ov4, ir4, last4;
  logic [7:0]  dout4;
  logic [7:0]  din1;
  logic        v1, rdy1, ov1, ir1, last1;
  logic [7:0]  dout1;

  exp_t q4[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;
  bit   rnd_rdy = 1'b0;
  bit   has4, has1;

  always #5 clk = ~clk;

  data_serializer #(.BITS(8), .WORDS(4)) u4 (
    .i_clk  (clk),
    .i_rst  (rst_n),
    .i_Din  (din4),
    .i_valid(v4),
    .o_ready(rdy4),
    .o_Dout (dout4),
    .o_valid(ov4),
    .i_ready(ir4),
    .o_last (last4)
  );

  data_serializer #(.BITS(8), .WORDS(1)) u1 (
    .i_clk  (clk),
    .i_rst  (rst_n),
    .i_Din  (din1),
    .i_valid(v1),
    .o_ready(rdy1),
    .o_Dout (dout1),
    .o_valid(ov1),
    .i_ready(ir1),
    .o_last (last1)
  );

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word until accepted; leaves valid high
  task automatic send(input bit which, input logic [31:0] w);
    bit acc;
    if (which) begin din1 = w[7:0]; v1 = 1'b1; end
    else       begin din4 = w;      v4 = 1'b1; end
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      acc = which ? rdy1 : rdy4;
      tick();
      if (acc) return;
    end
    chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (q4.size() == 0 && q1.size() == 0) break;
    end
    chk("drain", q4.size() + q1.size(), 0);
    tick();
  endtask

  // Reference model: accepted word becomes slices, top first
  always @(negedge clk) begin
    #1;
    if (rst_n && v4 && rdy4)
      for (int k = 3; k >= 0; k--)
        q4.push_back('{d: din4[k*8 +: 8], l: (k == 0)});
    if (rst_n && v1 && rdy1)
      q1.push_back('{d: din1, l: 1'b1});
  end

  // Monitor for the 4-slice instance
  always @(negedge clk) begin
    if (rst_n) begin
      has4 = (q4.size() > 0);
      chk("valid4", ov4, has4);
      chk("ready4", rdy4, has4 ? (q4[0].l && ir4) : 1'b1);
      if (ov4 && has4) begin
        chk("dout4", dout4, q4[0].d);
        chk("last4", last4, q4[0].l);
        if (ir4) void'(q4.pop_front());
      end
    end
  end

  // Monitor for the single-slice instance
  always @(negedge clk) begin
    if (rst_n) begin
      has1 = (q1.size() > 0);
      chk("valid1", ov1, has1);
      chk("ready1", rdy1, has1 ? (q1[0].l && ir1) : 1'b1);
      if (ov1 && has1) begin
        chk("dout1", dout1, q1[0].d);
        chk("last1", last1, q1[0].l);
        if (ir1) void'(q1.pop_front());
      end
    end
  end

  // Random downstream backpressure
  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      ir4 = ($urandom_range(0, 9) < 7);
    end
  end

  initial begin
    rst_n = 1'b0;
    din4 = '0; v4 = 1'b0; ir4 = 1'b1;
    din1 = '0; v1 = 1'b0; ir1 = 1'b1;
    #3;
    chk("rst_ready", rdy4, 0);
    chk("rst_valid", ov4, 0);
    chk("rst_dout", dout4, 0);
    chk("rst_last", last4, 0);
    chk("rst_ready1", rdy1, 0);
    #9 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", rdy4, 1);
    tick();

    // single word, free-running downstream
    send(0, 32'hDDCCBBAA);
    v4 = 1'b0;
    drain();

    // backpressure while CC is showing
    send(0, 32'hDDCCBBAA);
    v4 = 1'b0;
    tick();
    ir4 = 1'b0;
    repeat (3) tick();
    ir4 = 1'b1;
    drain();

    // back-to-back, second word stalls until last slice
    send(0, 32'h44332211);
    send(0, 32'h88776655);
    v4 = 1'b0;
    drain();

    // asynchronous reset while BB is showing
    send(0, 32'hDDCCBBAA);
    v4 = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", ov4, 0);
    chk("arst_dout", dout4, 0);
    chk("arst_ready", rdy4, 0);
    chk("arst_last", last4, 0);
    q4.delete();
    q1.delete();
    #10 rst_n = 1'b1;
    @(negedge clk);
    chk("arst_rel_ready", rdy4, 1);
    chk("arst_rel_valid", ov4, 0);
    tick();
    repeat (5) tick();

    // single-slice instance streaming
    send(1, 32'h01);
    send(1, 32'h02);
    send(1, 32'h03);
    v1 = 1'b0;
    drain();

    // random words, gaps and backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(0, $urandom);
      if ($urandom_range(0, 2) == 0) begin
        v4 = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
    end
    v4 = 1'b0;
    rnd_rdy = 1'b0;
    tick();
    ir4 = 1'b1;
    drain();

    repeat (4) tick();
    chk("q_empty", q4.size() + q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
